// File: rtl/heart_overlay.sv
// Lives-indicator overlay: maps pixels onto a row of heart slots, drives the
// sprite ROM, composites its output over the background, and owns the lives/blink state.
//
// state | meaning
// IDLE  | no animation; slots drawn purely from the lives count
// BLINK | slot blink_slot toggles visibility every BLINK_FRAMES frames
module heart_overlay #(
  parameter int SPR_W         = 64,
  parameter int SPR_H         = 20,
  parameter int SPACING       = 68,
  parameter int MAX_LIVES     = 5,
  parameter int INIT_LIVES    = 3,
  parameter int BLINK_FRAMES  = 8,
  parameter int BLINK_TOGGLES = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_start,
  input  logic        pixel_valid,
  input  logic [10:0] hcount,
  input  logic [10:0] vcount,
  input  logic [15:0] bg_rgb,
  input  logic [10:0] origin_x,
  input  logic [10:0] origin_y,
  input  logic        life_lost,
  input  logic        life_gain,
  input  logic        lives_load,
  input  logic [2:0]  lives_init,
  output logic [5:0]  rom_x,
  output logic [5:0]  rom_y,
  input  logic [15:0] rom_rgb,
  output logic        out_valid,
  output logic [15:0] out_rgb,
  output logic [2:0]  lives,
  output logic        blinking
);

  localparam int FW = $clog2(BLINK_FRAMES + 1);
  localparam int TW = $clog2(BLINK_TOGGLES + 1);

  typedef enum logic {IDLE, BLINK} state_t;

  state_t        state;
  logic [2:0]    blink_slot;
  logic          blink_on;
  logic [FW-1:0] frame_cnt;
  logic [TW-1:0] toggle_cnt;

  logic [10:0] dx, dy, base, lx;
  logic [2:0]  slot;
  logic        in_strip, drawn, hit;
  logic [2:0]  init_clamped;

  logic        hit0, valid0, hit1, valid1;
  logic [15:0] bg0, bg1;

  assign blinking     = (state == BLINK);
  assign init_clamped = (lives_init > 3'(MAX_LIVES)) ? 3'(MAX_LIVES) : lives_init;

  // Slot index via a constant compare chain rather than a divider.
  always_comb begin
    dx   = hcount - origin_x;
    dy   = vcount - origin_y;
    slot = '0;
    base = '0;
    for (int k = 1; k < MAX_LIVES; k++) begin
      if (dx >= 11'(k * SPACING)) begin
        slot = 3'(k);
        base = 11'(k * SPACING);
      end
    end
    lx       = dx - base;
    in_strip = (hcount >= origin_x) && (vcount >= origin_y) &&
               (dy < 11'(SPR_H)) && (dx < 11'(MAX_LIVES * SPACING));
    drawn    = (slot < lives) || (blinking && slot == blink_slot && blink_on);
    hit      = pixel_valid && in_strip && (lx < 11'(SPR_W)) && drawn;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rom_x     <= '0;
      rom_y     <= '0;
      hit0      <= 1'b0;
      valid0    <= 1'b0;
      bg0       <= '0;
      hit1      <= 1'b0;
      valid1    <= 1'b0;
      bg1       <= '0;
      out_valid <= 1'b0;
      out_rgb   <= '0;
    end else begin
      rom_x     <= hit ? lx[5:0] : 6'd0;
      rom_y     <= hit ? dy[5:0] : 6'd0;
      hit0      <= hit;
      valid0    <= pixel_valid;
      bg0       <= bg_rgb;
      hit1      <= hit0;
      valid1    <= valid0;
      bg1       <= bg0;
      out_valid <= valid1;
      // 16'h0000 from the ROM is the transparent colour.
      out_rgb   <= (hit1 && rom_rgb != 16'h0000) ? rom_rgb : bg1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      lives      <= 3'(INIT_LIVES);
      blink_slot <= '0;
      blink_on   <= 1'b0;
      frame_cnt  <= '0;
      toggle_cnt <= '0;
    end else begin
      if (state == BLINK && frame_start) begin
        if (frame_cnt == FW'(BLINK_FRAMES - 1)) begin
          frame_cnt  <= '0;
          blink_on   <= ~blink_on;
          toggle_cnt <= toggle_cnt + 1'b1;
          if (toggle_cnt == TW'(BLINK_TOGGLES - 1))
            state <= IDLE;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end
      // Later assignments deliberately override the frame-tick update above.
      if (lives_load) begin
        lives <= init_clamped;
        state <= IDLE;
      end else if (life_lost && !life_gain) begin
        if (lives != 3'd0) begin
          lives      <= lives - 1'b1;
          blink_slot <= lives - 1'b1;
          blink_on   <= 1'b1;
          frame_cnt  <= '0;
          toggle_cnt <= '0;
          state      <= BLINK;
        end
      end else if (life_gain && !life_lost && lives < 3'(MAX_LIVES)) begin
        lives <= lives + 1'b1;
        if (state == BLINK && lives == blink_slot)
          state <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_heart_overlay.sv
// Directed bench for heart_overlay with a registered sprite ROM model.
module tb_heart_overlay;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_start = 1'b0;
  logic        pixel_valid = 1'b0;
  logic [10:0] hcount = '0;
  logic [10:0] vcount = '0;
  logic [15:0] bg_rgb = '0;
  logic [10:0] origin_x = 11'd100;
  logic [10:0] origin_y = 11'd50;
  logic        life_lost = 1'b0;
  logic        life_gain = 1'b0;
  logic        lives_load = 1'b0;
  logic [2:0]  lives_init = '0;
  logic [5:0]  rom_x, rom_y;
  logic [15:0] rom_rgb = '0;
  logic        out_valid;
  logic [15:0] out_rgb;
  logic [2:0]  lives;
  logic        blinking;

  int vectors = 0;
  int miscompares = 0;

  heart_overlay dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .pixel_valid(pixel_valid),
    .hcount(hcount), .vcount(vcount), .bg_rgb(bg_rgb),
    .origin_x(origin_x), .origin_y(origin_y),
    .life_lost(life_lost), .life_gain(life_gain), .lives_load(lives_load),
    .lives_init(lives_init), .rom_x(rom_x), .rom_y(rom_y), .rom_rgb(rom_rgb),
    .out_valid(out_valid), .out_rgb(out_rgb), .lives(lives), .blinking(blinking)
  );

  always #5 clk = ~clk;

  // Coarse heart mask: opaque red inside, transparent border.
  always @(posedge clk)
    rom_rgb <= (rom_x >= 6'd4 && rom_x < 6'd60 && rom_y >= 6'd2 && rom_y < 6'd18)
               ? 16'hF800 : 16'h0000;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pix(input string tag, input logic [10:0] x, input logic [10:0] y,
                     input logic [15:0] bg, input logic [5:0] ex_rx, input logic [5:0] ex_ry,
                     input logic [15:0] ex_rgb);
    @(negedge clk);
    hcount = x; vcount = y; bg_rgb = bg; pixel_valid = 1'b1;
    @(negedge clk);
    pixel_valid = 1'b0;
    chk({tag, "_rom_x"}, 16'(rom_x), 16'(ex_rx));
    chk({tag, "_rom_y"}, 16'(rom_y), 16'(ex_ry));
    @(negedge clk);
    @(negedge clk);
    chk({tag, "_valid"}, 16'(out_valid), 16'd1);
    chk({tag, "_rgb"}, out_rgb, ex_rgb);
  endtask

  task automatic pulse(input logic lost, input logic gain, input logic load,
                       input logic [2:0] init, input logic fs);
    @(negedge clk);
    life_lost = lost; life_gain = gain; lives_load = load; lives_init = init; frame_start = fs;
    @(negedge clk);
    life_lost = 1'b0; life_gain = 1'b0; lives_load = 1'b0; frame_start = 1'b0;
  endtask

  initial begin
    #12;
    chk("rst_rom_x", 16'(rom_x), 16'd0);
    chk("rst_out_valid", 16'(out_valid), 16'd0);
    chk("rst_out_rgb", out_rgb, 16'd0);
    chk("rst_lives", 16'(lives), 16'd3);
    chk("rst_blinking", 16'(blinking), 16'd0);
    @(negedge clk);
    rst_n = 1'b1;

    pix("passthru", 11'd10, 11'd10, 16'h07E0, 6'd0, 6'd0, 16'h07E0);
    @(negedge clk);
    chk("valid_drop", 16'(out_valid), 16'd0);
    pix("hit_s1", 11'd178, 11'd55, 16'h001F, 6'd10, 6'd5, 16'hF800);
    pix("transp_s1", 11'd168, 11'd55, 16'h001F, 6'd0, 6'd5, 16'h001F);
    pix("gap_s1", 11'd234, 11'd55, 16'h001F, 6'd0, 6'd0, 16'h001F);
    pix("hit_s2", 11'd246, 11'd55, 16'h001F, 6'd10, 6'd5, 16'hF800);
    pix("undrawn_s3", 11'd314, 11'd55, 16'h001F, 6'd0, 6'd0, 16'h001F);
    pix("below_strip", 11'd178, 11'd70, 16'h001F, 6'd0, 6'd0, 16'h001F);

    repeat (3) pulse(1'b0, 1'b1, 1'b0, 3'd0, 1'b0);
    chk("gain_sat", 16'(lives), 16'd5);
    pulse(1'b0, 1'b1, 1'b0, 3'd0, 1'b0);
    chk("gain_at_max", 16'(lives), 16'd5);
    pix("hit_s4", 11'd382, 11'd55, 16'h001F, 6'd10, 6'd5, 16'hF800);
    pulse(1'b1, 1'b1, 1'b0, 3'd0, 1'b0);
    chk("lost_gain_same", 16'(lives), 16'd5);
    chk("lost_gain_noblink", 16'(blinking), 16'd0);
    pulse(1'b0, 1'b0, 1'b1, 3'd2, 1'b0);
    chk("load_2", 16'(lives), 16'd2);
    pulse(1'b0, 1'b0, 1'b1, 3'd7, 1'b0);
    chk("load_clamp", 16'(lives), 16'd5);
    repeat (6) pulse(1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
    chk("lost_floor", 16'(lives), 16'd0);
    chk("lost_floor_blink", 16'(blinking), 16'd1);
    pulse(1'b0, 1'b0, 1'b1, 3'd3, 1'b0);
    chk("load_cancels_blink", 16'(blinking), 16'd0);
    chk("load_3", 16'(lives), 16'd3);

    pulse(1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
    chk("blink_lives", 16'(lives), 16'd2);
    chk("blink_start", 16'(blinking), 16'd1);
    pix("blink_f0", 11'd246, 11'd55, 16'h001F, 6'd10, 6'd5, 16'hF800);
    repeat (7) pulse(1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
    pix("blink_f7", 11'd246, 11'd55, 16'h001F, 6'd10, 6'd5, 16'hF800);
    pulse(1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
    pix("blink_f8", 11'd246, 11'd55, 16'h001F, 6'd0, 6'd0, 16'h001F);
    repeat (7) pulse(1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
    pix("blink_f15", 11'd246, 11'd55, 16'h001F, 6'd0, 6'd0, 16'h001F);
    pulse(1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
    pix("blink_f16", 11'd246, 11'd55, 16'h001F, 6'd10, 6'd5, 16'hF800);
    repeat (31) pulse(1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
    chk("blink_f47", 16'(blinking), 16'd1);
    pulse(1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
    chk("blink_f48_end", 16'(blinking), 16'd0);
    pix("blink_done", 11'd246, 11'd55, 16'h001F, 6'd0, 6'd0, 16'h001F);

    pulse(1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
    chk("lost_to_1", 16'(lives), 16'd1);
    pulse(1'b0, 1'b1, 1'b0, 3'd0, 1'b0);
    chk("gain_cancel_lives", 16'(lives), 16'd2);
    chk("gain_cancel_blink", 16'(blinking), 16'd0);

    pulse(1'b0, 1'b0, 1'b1, 3'd5, 1'b0);
    @(negedge clk);
    hcount = 11'd178; vcount = 11'd55; bg_rgb = 16'h001F; pixel_valid = 1'b1;
    repeat (3) @(negedge clk);
    chk("stream_rgb", out_rgb, 16'hF800);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rgb", out_rgb, 16'd0);
    chk("async_valid", 16'(out_valid), 16'd0);
    chk("async_rom_x", 16'(rom_x), 16'd0);
    chk("async_lives", 16'(lives), 16'd3);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("rel_valid_n1", 16'(out_valid), 16'd0);
    @(negedge clk);
    chk("rel_valid_n2", 16'(out_valid), 16'd1);
    chk("rel_rgb_n2", out_rgb, 16'hF800);
    pixel_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
